mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control FSM for the MIPS core. It sits beside the PC register, IR, GRF, ALU and DM, and sequences one instruction over 3–5 cycles. Each cycle it drives the PC write-enable and next-PC select, the IR latch, and the register-file, ALU, extender and memory controls. It decodes the latched IR, and it takes the ALU `zero` flag to resolve branches.

## Interface
Parameters:
- `RESET_STATE`, default 3'd0 (FETCH): state loaded on reset.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high. Clock is `clk`.
- `instr`, input, 32: IR contents. Stable from DECODE onward.
- `zero`, input, 1: ALU equality flag. Sampled in EXEC.
- `pc_en`, output, 1: PC write enable.
- `npc_sel`, output, 2: next-PC source.
  - 0 = PC+4.
  - 1 = PC + (sext(imm16)<<2). PC already holds the delay-free PC+4.
  - 2 = {PC[31:28], imm26, 2'b00}.
  - 3 = GPR[rs].
- `ir_en`, output, 1: IR latch enable.
- `reg_we`, output, 1: GRF write enable.
- `reg_dst`, output, 2: write address. 0 = rt, 1 = rd, 2 = 31.
- `wd_sel`, output, 2: write data. 0 = ALU, 1 = DM read, 2 = PC.
- `alu_src`, output, 1: ALU B operand. 0 = GPR[rt], 1 = extended imm.
- `alu_op`, output, 2: 0 = ADD, 1 = SUB, 2 = OR.
- `ext_op`, output, 2: 0 = zero-extend, 1 = sign-extend, 2 = imm16<<16.
- `mem_we`, output, 1: DM write enable.
- `done`, output, 1: one-cycle pulse in the final cycle of each instruction.
- `state`, output, 3: current state, for debug.

## Operation
- States: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4. Codes 5–7 are illegal and go to FETCH on the next edge, with all enables 0.
- Decode uses op = `instr[31:26]` and funct = `instr[5:0]`.
  - R-type (op 000000): addu funct 100001, subu funct 100011, jr funct 001000.
  - I-type: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111.
  - J-type: j 000010, jal 000011.
  - Anything else (including sll/nop) is UNKNOWN.
- Outputs are combinational from (state, instr, zero). All enables default to 0 and all selects default to 0.
- The state register is the only flop.
- FETCH (all instructions): `ir_en`=1, `pc_en`=1, `npc_sel`=0. Next state is DECODE.
- DECODE:
  - j: `pc_en`=1, `npc_sel`=2, `done`=1; next FETCH.
  - jal: `pc_en`=1, `npc_sel`=2, `reg_we`=1, `reg_dst`=2, `wd_sel`=2, `done`=1; next FETCH. The GRF captures the old PC on the same edge the PC updates.
  - jr: `pc_en`=1, `npc_sel`=3, `done`=1; next FETCH.
  - UNKNOWN: `done`=1; next FETCH (executes as a no-op).
  - Everything else: next EXEC.
- EXEC:
  - addu: `alu_op`=0, `alu_src`=0.
  - subu: `alu_op`=1, `alu_src`=0.
  - ori: `alu_op`=2, `alu_src`=1, `ext_op`=0.
  - lui: `alu_op`=2, `alu_src`=1, `ext_op`=2 (computes 0|imm<<16).
  - lw/sw: `alu_op`=0, `alu_src`=1, `ext_op`=1.
  - beq: `alu_op`=1, `alu_src`=0, `ext_op`=1, `pc_en`=`zero`, `npc_sel`=1, `done`=1; next FETCH.
  - Next state: lw/sw go to MEM; addu/subu/ori/lui go to WB.
- MEM:
  - lw and sw hold the EXEC ALU/ext controls.
  - sw: `mem_we`=1, `done`=1; next FETCH.
  - lw: next WB.
- WB:
  - `reg_we`=1, `done`=1; next FETCH. The EXEC ALU controls are held.
  - `reg_dst`=1 for addu/subu, 0 otherwise.
  - `wd_sel`=1 for lw, 0 otherwise.

## Timing
- Reset: on a `clk` edge with `reset`=1, state becomes FETCH. This applies in any state, including mid-instruction.
- In the reset cycle all outputs are 0 except `state`.
  - `state` is RESET_STATE.
  - No write enable (`pc_en`, `ir_en`, `reg_we`, `mem_we`) may be 1 in that cycle.
  - The first FETCH occurs in the first cycle after `reset` deasserts.
- Latency in cycles: j/jal/jr/UNKNOWN = 2, beq = 3, sw = 4, addu/subu/ori/lui = 4, lw = 5.
- `done` is exactly one cycle wide, once per instruction, and never in FETCH.
- `pc_en` is asserted at most twice per instruction: once in FETCH, and at most once more in DECODE or EXEC.
- beq not taken: `pc_en`=0 in EXEC.

## Test plan
- Reset is held 2 cycles and then released, with `instr`=0 → `state`=0 and all enables 0 while reset is held. The first post-reset cycle then shows `ir_en`=1, `pc_en`=1, `npc_sel`=0.
- lw: `instr`=0x8C0A0004 → the state sequence is 0,1,2,3,4. In WB: `reg_we`=1, `wd_sel`=1, `reg_dst`=0, `done`=1 only there.
- beq: `instr`=0x1000FFFF.
  - With `zero`=1 → EXEC shows `pc_en`=1, `npc_sel`=1, `done`=1.
  - With `zero`=0 → EXEC shows `pc_en`=0, `done`=1.
- jal: `instr`=0x0C000C00 → DECODE shows `pc_en`=1, `npc_sel`=2, `reg_we`=1, `reg_dst`=2, `wd_sel`=2. The next state is FETCH.
- Run sw 0xAC0A0008 followed by UNKNOWN 0x00000000 → sw shows `mem_we`=1 only in MEM, with 4 cycles to `done`. The no-op shows `done` in DECODE with no writes.
- Assert `reset` in MEM of lw → FETCH on the next edge with no `reg_we` pulse. Also force `state` to 6 → FETCH on the next edge.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: decoded-instruction inputs and datapath control outputs of the multi-cycle controller.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        pc_en;
  logic [1:0]  npc_sel;
  logic        ir_en;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic [1:0]  ext_op;
  logic        mem_we;
  logic        done;
  modport master (
    input  instr, zero,
    output pc_en, npc_sel, ir_en, reg_we, reg_dst, wd_sel, alu_src, alu_op, ext_op, mem_we, done
  );
  modport slave (
    output instr, zero,
    input  pc_en, npc_sel, ir_en, reg_we, reg_dst, wd_sel, alu_src, alu_op, ext_op, mem_we, done
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM sequencing FETCH/DECODE/EXEC/MEM/WB.
module mc_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  mc_ctrl_if.master  bus,
  output logic [2:0] state
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t state_q, state_d;
  logic [5:0] op, funct;
  logic rtype, addu, subu, jr, ori, lw, sw, beq, lui, j, jal, unk;
  logic [1:0] alu_op_i, ext_op_i;
  logic alu_src_i;
  assign op    = bus.instr[31:26];
  assign funct = bus.instr[5:0];
  assign rtype = op == 6'b000000;
  assign addu  = rtype && funct == 6'b100001;
  assign subu  = rtype && funct == 6'b100011;
  assign jr    = rtype && funct == 6'b001000;
  assign ori   = op == 6'b001101;
  assign lw    = op == 6'b100011;
  assign sw    = op == 6'b101011;
  assign beq   = op == 6'b000100;
  assign lui   = op == 6'b001111;
  assign j     = op == 6'b000010;
  assign jal   = op == 6'b000011;
  assign unk   = !(addu || subu || jr || ori || lw || sw || beq || lui || j || jal);
  // ALU/extender setup chosen in EXEC and held through MEM and WB
  assign alu_op_i  = (subu || beq) ? 2'd1 : (ori || lui) ? 2'd2 : 2'd0;
  assign alu_src_i = ori || lui || lw || sw;
  assign ext_op_i  = lui ? 2'd2 : (lw || sw || beq) ? 2'd1 : 2'd0;
  always_ff @(posedge clk)
    state_q <= reset ? state_t'(RESET_STATE) : state_d;
  always_comb begin
    state_d     = FETCH;
    bus.pc_en   = 1'b0;
    bus.npc_sel = 2'd0;
    bus.ir_en   = 1'b0;
    bus.reg_we  = 1'b0;
    bus.reg_dst = 2'd0;
    bus.wd_sel  = 2'd0;
    bus.alu_src = 1'b0;
    bus.alu_op  = 2'd0;
    bus.ext_op  = 2'd0;
    bus.mem_we  = 1'b0;
    bus.done    = 1'b0;
    if (!reset) begin
      if (state_q == EXEC || state_q == MEM || state_q == WB) begin
        bus.alu_op  = alu_op_i;
        bus.alu_src = alu_src_i;
        bus.ext_op  = ext_op_i;
      end
      case (state_q)
        FETCH: begin
          bus.ir_en = 1'b1;
          bus.pc_en = 1'b1;
          state_d   = DECODE;
        end
        DECODE: begin
          bus.pc_en   = j || jal || jr;
          bus.npc_sel = jr ? 2'd3 : (j || jal) ? 2'd2 : 2'd0;
          bus.reg_we  = jal;
          bus.reg_dst = jal ? 2'd2 : 2'd0;
          bus.wd_sel  = jal ? 2'd2 : 2'd0;
          bus.done    = j || jal || jr || unk;
          if (!(j || jal || jr || unk)) state_d = EXEC;
        end
        EXEC: begin
          bus.pc_en   = beq && bus.zero;
          bus.npc_sel = beq ? 2'd1 : 2'd0;
          bus.done    = beq;
          if (lw || sw) state_d = MEM;
          else if (!beq) state_d = WB;
        end
        MEM: begin
          bus.mem_we = sw;
          bus.done   = sw;
          if (!sw) state_d = WB;
        end
        WB: begin
          bus.reg_we  = 1'b1;
          bus.done    = 1'b1;
          bus.reg_dst = (addu || subu) ? 2'd1 : 2'd0;
          bus.wd_sel  = lw ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end
  assign state = state_q;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed-vector check of mc_ctrl state sequence and per-cycle controls.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] state, state2;
  int vectors = 0;
  int errors = 0;
  mc_ctrl_if bus ();
  mc_ctrl_if bus2 ();
  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus), .state(state));
  mc_ctrl #(.RESET_STATE(3'd6)) dut2 (.clk(clk), .reset(reset), .bus(bus2), .state(state2));
  always #5 clk = ~clk;
  function automatic logic [15:0] cv(logic pe, logic [1:0] ns, logic ir, logic we, logic [1:0] rd,
                                     logic [1:0] wd, logic as, logic [1:0] ao, logic [1:0] eo,
                                     logic mw, logic dn);
    return {pe, ns, ir, we, rd, wd, as, ao, eo, mw, dn};
  endfunction
  function automatic logic [15:0] obs(logic pe, logic [1:0] ns, logic ir, logic we, logic [1:0] rd,
                                      logic [1:0] wd, logic as, logic [1:0] ao, logic [1:0] eo,
                                      logic mw, logic dn);
    return {pe, ns, ir, we, rd, wd, as, ao, eo, mw, dn};
  endfunction
  task automatic chk(string tag, logic [2:0] os, logic [2:0] es, logic [15:0] oc, logic [15:0] ec);
    vectors++;
    assert (os === es) else begin
      errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, os, es);
    end
    vectors++;
    assert (oc === ec) else begin
      errors++;
      $error("FAIL %s ctrl observed=%h expected=%h", tag, oc, ec);
    end
  endtask
  // checks one cycle mid-period, then returns just after the next rising edge for input changes
  task automatic cyc(string tag, logic [2:0] es, logic [15:0] ec, bit ck2 = 0,
                     logic [2:0] es2 = 3'd0, logic [15:0] ec2 = 16'h0);
    @(negedge clk);
    chk(tag, state, es, obs(bus.pc_en, bus.npc_sel, bus.ir_en, bus.reg_we, bus.reg_dst, bus.wd_sel,
                            bus.alu_src, bus.alu_op, bus.ext_op, bus.mem_we, bus.done), ec);
    if (ck2)
      chk({tag, "_b"}, state2, es2, obs(bus2.pc_en, bus2.npc_sel, bus2.ir_en, bus2.reg_we, bus2.reg_dst,
                                        bus2.wd_sel, bus2.alu_src, bus2.alu_op, bus2.ext_op, bus2.mem_we,
                                        bus2.done), ec2);
    @(posedge clk);
    #1;
  endtask
  logic [15:0] f, z, lw_e, lw_w, beq_t, beq_n, jal_d, sw_m, unk_d, addu_w, ori_e, ori_w, lui_e, jr_d;
  initial begin
    f      = cv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    z      = 16'h0;
    lw_e   = cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    lw_w   = cv(0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 1);
    beq_t  = cv(1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    beq_n  = cv(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    jal_d  = cv(1, 2, 0, 1, 2, 2, 0, 0, 0, 0, 1);
    sw_m   = cv(0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    unk_d  = cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    addu_w = cv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    ori_e  = cv(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    ori_w  = cv(0, 0, 0, 1, 0, 0, 1, 2, 0, 0, 1);
    lui_e  = cv(0, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0);
    jr_d   = cv(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    bus.instr = 32'h0; bus.zero = 1'b0;
    bus2.instr = 32'h0; bus2.zero = 1'b0;
    cyc("rst0", 0, z, 1, 6, z);
    cyc("rst1", 0, z, 1, 6, z);
    reset = 1'b0;
    bus.instr = 32'h8C0A0004;
    cyc("lw_f", 0, f, 1, 6, z);
    cyc("lw_d", 1, z, 1, 0, f);
    cyc("lw_e", 2, lw_e);
    cyc("lw_m", 3, lw_e);
    cyc("lw_w", 4, lw_w);
    bus.instr = 32'h1000FFFF; bus.zero = 1'b1;
    cyc("beqt_f", 0, f);
    cyc("beqt_d", 1, z);
    cyc("beqt_e", 2, beq_t);
    bus.zero = 1'b0;
    cyc("beqn_f", 0, f);
    cyc("beqn_d", 1, z);
    cyc("beqn_e", 2, beq_n);
    bus.instr = 32'h0C000C00;
    cyc("jal_f", 0, f);
    cyc("jal_d", 1, jal_d);
    bus.instr = 32'hAC0A0008;
    cyc("sw_f", 0, f);
    cyc("sw_d", 1, z);
    cyc("sw_e", 2, lw_e);
    cyc("sw_m", 3, sw_m);
    bus.instr = 32'h00000000;
    cyc("unk_f", 0, f);
    cyc("unk_d", 1, unk_d);
    bus.instr = 32'h014B4821;
    cyc("addu_f", 0, f);
    cyc("addu_d", 1, z);
    cyc("addu_e", 2, z);
    cyc("addu_w", 4, addu_w);
    bus.instr = 32'h014B4823;
    cyc("subu_f", 0, f);
    cyc("subu_d", 1, z);
    cyc("subu_e", 2, cv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    cyc("subu_w", 4, cv(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1));
    bus.instr = 32'h354A1234;
    cyc("ori_f", 0, f);
    cyc("ori_d", 1, z);
    cyc("ori_e", 2, ori_e);
    cyc("ori_w", 4, ori_w);
    bus.instr = 32'h3C0A1234;
    cyc("lui_f", 0, f);
    cyc("lui_d", 1, z);
    cyc("lui_e", 2, lui_e);
    cyc("lui_w", 4, cv(0, 0, 0, 1, 0, 0, 1, 2, 2, 0, 1));
    bus.instr = 32'h01400008;
    cyc("jr_f", 0, f);
    cyc("jr_d", 1, jr_d);
    bus.instr = 32'h8C0A0004;
    cyc("lwr_f", 0, f);
    cyc("lwr_d", 1, z);
    cyc("lwr_e", 2, lw_e);
    reset = 1'b1;
    cyc("lwr_m", 3, z);
    cyc("lwr_rst", 0, z);
    reset = 1'b0;
    cyc("lwr_f2", 0, f);
    cyc("lwr_d2", 1, z);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
